fre_word_meas: RTL and testbench

FRE_WORD_MEAS -- requirements
Module: fre_word_meas

---
 rtl/fre_word_meas.sv | 120 ++++++++++++
 tb/tb_fre_word_meas.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/fre_word_meas.sv
// Gated edge-count frequency meter: counts comparator rising edges over a
// 2^GATE_LOG2-cycle window and converts the count into a DDS tuning word.
module fre_word_meas #(
    parameter int GATE_LOG2 = 20,
    parameter int HYST      = 16,
    parameter int TOL       = 2
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic signed [9:0]       data_in,
    input  logic                    fre_ready,
    output logic signed [47:0]      Fre,
    output logic                    fre_valid,
    output logic [GATE_LOG2:0]      edge_cnt,
    output logic                    no_signal,
    output logic                    fre_stable
);

    localparam int CW = GATE_LOG2 + 1;
    localparam logic [1:0] ARM     = 2'd0;
    localparam logic [1:0] MEASURE = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    localparam logic signed [9:0] HYST_HI  = 10'(HYST);
    localparam logic signed [9:0] HYST_LO  = 10'(-HYST);
    localparam logic [GATE_LOG2-1:0] GATE_LAST = '1;
    localparam logic [CW-1:0] ACC_MAX = '1;
    localparam logic [CW-1:0] TOL_W   = CW'(TOL);

    logic [1:0]           state;
    logic [GATE_LOG2-1:0] gate;
    logic [CW-1:0]        acc;
    logic                 cmp;
    logic                 cmp_prev;
    logic                 primed;
    logic                 rise;
    logic [CW-1:0]        acc_final;
    logic [CW-1:0]        diff;
    logic [47:0]          fre_word;

    // An edge only counts once the comparator has seen a genuine low level,
    // so a signal that is already high at reset release is not a false edge.
    assign rise      = cmp & ~cmp_prev & primed;
    assign acc_final = (rise && (acc != ACC_MAX)) ? acc + 1'b1 : acc;
    assign diff      = (acc_final >= edge_cnt) ? acc_final - edge_cnt : edge_cnt - acc_final;
    assign fre_word  = 48'(acc_final) << (41 - GATE_LOG2);
    assign fre_valid = (state == DONE);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cmp      <= 1'b0;
            cmp_prev <= 1'b0;
            primed   <= 1'b0;
        end else begin
            cmp_prev <= cmp;
            if (data_in > HYST_HI) begin
                cmp <= 1'b1;
            end else if (data_in < HYST_LO) begin
                cmp <= 1'b0;
            end
            if (data_in <= HYST_LO) begin
                primed <= 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= ARM;
            gate       <= '0;
            acc        <= '0;
            Fre        <= '0;
            edge_cnt   <= '0;
            no_signal  <= 1'b0;
            fre_stable <= 1'b0;
        end else begin
            case (state)
                ARM: begin
                    if (rise) begin
                        state <= MEASURE;
                        gate  <= '0;
                        acc   <= '0;
                    end else if (gate == GATE_LAST) begin
                        state      <= DONE;
                        Fre        <= '0;
                        edge_cnt   <= '0;
                        no_signal  <= 1'b1;
                        fre_stable <= 1'b0;
                    end else begin
                        gate <= gate + 1'b1;
                    end
                end
                MEASURE: begin
                    // The terminal cycle's own edge is folded in via acc_final.
                    if (gate == GATE_LAST) begin
                        state      <= DONE;
                        gate       <= '0;
                        edge_cnt   <= acc_final;
                        Fre        <= fre_word;
                        no_signal  <= 1'b0;
                        fre_stable <= (diff <= TOL_W) && (acc_final != '0) && !no_signal;
                    end else begin
                        gate <= gate + 1'b1;
                        acc  <= acc_final;
                    end
                end
                DONE: begin
                    if (fre_ready) begin
                        state <= ARM;
                        gate  <= '0;
                    end
                end
                default: begin
                    state <= ARM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fre_word_meas.sv
// Directed bench for fre_word_meas with a 1024-cycle gate: timeout, square
// waves at two periods, held handshake and asynchronous reset mid-measurement.
module tb_fre_word_meas;

    logic               sys_clk;
    logic               sys_rst_n;
    logic signed [9:0]  data_in;
    logic               fre_ready;
    logic signed [47:0] Fre;
    logic               fre_valid;
    logic [10:0]        edge_cnt;
    logic               no_signal;
    logic               fre_stable;

    int  check_count;
    int  fail_count;
    int  period;
    int  phase;
    bit  wave_on;
    int  wait_cycles;

    fre_word_meas #(.GATE_LOG2(10), .HYST(16), .TOL(2)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .data_in    (data_in),
        .fre_ready  (fre_ready),
        .Fre        (Fre),
        .fre_valid  (fre_valid),
        .edge_cnt   (edge_cnt),
        .no_signal  (no_signal),
        .fre_stable (fre_stable)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One clock of stimulus: inputs change on the falling edge, low half first.
    task automatic applyStimulus();
        @(negedge sys_clk);
        if (wave_on) begin
            data_in = (phase < period / 2) ? -10'sd200 : 10'sd200;
            phase   = (phase + 1) % period;
        end
    endtask

    task automatic waitValid(input int budget);
        wait_cycles = 0;
        while (!fre_valid && wait_cycles < budget) begin
            applyStimulus();
            wait_cycles++;
        end
        checkOutput("valid_seen", {63'd0, fre_valid}, 64'd1);
    endtask

    task automatic checkResult(input string tag, input logic [10:0] cnt, input logic [47:0] word,
                               input logic nosig, input logic stable);
        $display("[TB] result %s", tag);
        checkOutput({tag, "_edge_cnt"},  {53'd0, edge_cnt}, {53'd0, cnt});
        checkOutput({tag, "_fre"},       {16'd0, Fre},      {16'd0, word});
        checkOutput({tag, "_no_signal"}, {63'd0, no_signal},  {63'd0, nosig});
        checkOutput({tag, "_stable"},    {63'd0, fre_stable}, {63'd0, stable});
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_fre"},       {16'd0, Fre},        64'd0);
        checkOutput({tag, "_edge_cnt"},  {53'd0, edge_cnt},   64'd0);
        checkOutput({tag, "_valid"},     {63'd0, fre_valid},  64'd0);
        checkOutput({tag, "_no_signal"}, {63'd0, no_signal},  64'd0);
        checkOutput({tag, "_stable"},    {63'd0, fre_stable}, 64'd0);
    endtask

    initial begin
        check_count = 0;
        fail_count  = 0;
        period      = 64;
        phase       = 0;
        wave_on     = 1'b0;
        data_in     = '0;
        fre_ready   = 1'b1;
        sys_rst_n   = 1'b0;

        repeat (3) applyStimulus();
        checkAllZero("reset");
        sys_rst_n = 1'b1;

        // Flat input: the ARM window must time out after exactly 1024 clocks.
        waitValid(1200);
        checkOutput("timeout_cycles", 64'(wait_cycles), 64'd1024);
        checkResult("timeout", 11'd0, 48'd0, 1'b1, 1'b0);
        applyStimulus();
        checkOutput("timeout_release", {63'd0, fre_valid}, 64'd0);

        wave_on = 1'b1;
        period  = 64;
        phase   = 0;
        waitValid(3000);
        checkResult("p64_first", 11'd16, 48'h0008_0000_0000, 1'b0, 1'b0);
        applyStimulus();

        waitValid(3000);
        checkResult("p64_second", 11'd16, 48'h0008_0000_0000, 1'b0, 1'b1);
        applyStimulus();

        // Consumer stalls for 50 clocks: result must hold.
        fre_ready = 1'b0;
        waitValid(3000);
        checkResult("p64_stall", 11'd16, 48'h0008_0000_0000, 1'b0, 1'b1);
        for (int i = 0; i < 50; i++) begin
            applyStimulus();
            checkOutput("stall_valid", {63'd0, fre_valid}, 64'd1);
            checkOutput("stall_fre", {16'd0, Fre}, 64'h0008_0000_0000);
            checkOutput("stall_cnt", {53'd0, edge_cnt}, 64'd16);
        end
        fre_ready = 1'b1;
        applyStimulus();
        checkOutput("stall_release", {63'd0, fre_valid}, 64'd0);

        period = 32;
        phase  = 0;
        waitValid(3000);
        checkResult("p32_first", 11'd32, 48'h0010_0000_0000, 1'b0, 1'b0);
        applyStimulus();

        waitValid(3000);
        checkResult("p32_second", 11'd32, 48'h0010_0000_0000, 1'b0, 1'b1);
        applyStimulus();

        // Asynchronous reset in the middle of a gate window.
        period = 64;
        phase  = 0;
        repeat (300) applyStimulus();
        checkOutput("pre_reset_valid", {63'd0, fre_valid}, 64'd0);
        #2;
        sys_rst_n = 1'b0;
        #1;
        checkAllZero("async_reset");
        repeat (2) applyStimulus();
        sys_rst_n = 1'b1;

        waitValid(3000);
        checkResult("after_reset", 11'd16, 48'h0008_0000_0000, 1'b0, 1'b0);
        applyStimulus();

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
